pid_channel_scheduler: RTL

- Time-multiplexes one incremental-PID arithmetic path across NUM_CH control channels.
- On each accepted sample strobe it snapshots every channel's target/feedback, then steps through the channels in order. For each enabled channel it computes the error, fetches that channel's error history (e(k-1), e(k-2)), evaluates du = Kp*(e0-e1) + Ki*e0 + Kd*(e0-2e1+e2) with one shared multiplier, and accumulates u with saturation.
- Sits between the AXI register bank (gains, enables, sample tick) and the per-channel actuator outputs.

---
 rtl/pid_pkg.sv | 56 +++++
 rtl/pid_mac_unit.sv | 72 +++++++
 rtl/pid_channel_scheduler.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/pid_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pid_pkg
// Brief    : Shared state encoding, operand-select codes, width helpers and
//            the output clamp used by the PID channel scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package pid_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_MUL_P = 3'd2,
        S_MUL_I = 3'd3,
        S_MUL_D = 3'd4,
        S_ACC   = 3'd5,
        S_NEXT  = 3'd6
    } pid_state_t;

    typedef enum logic [1:0] {
        SEL_P = 2'd0,
        SEL_I = 2'd1,
        SEL_D = 2'd2
    } mac_sel_t;

    // Working width of the clamp; must exceed ACC_W + 1 for any legal config.
    localparam int SAT_W = 128;

    function automatic int d1_width(input int val_length);
        return val_length + 1;
    endfunction

    function automatic int d2_width(input int val_length);
        return val_length + 2;
    endfunction

    function automatic int prod_width(input int val_length, input int coef_length);
        return val_length + coef_length + 2;
    endfunction

    function automatic int acc_width(input int val_length, input int coef_length);
        return val_length + coef_length + 4;
    endfunction

    function automatic logic signed [SAT_W-1:0] sat_clamp(
        input logic signed [SAT_W-1:0] value,
        input logic signed [SAT_W-1:0] lo,
        input logic signed [SAT_W-1:0] hi
    );
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pid_mac_unit.sv
`default_nettype none
// ============================================================================
// Module   : pid_mac_unit
// Brief    : Single shared signed multiplier with operand select feeding a
//            wide accumulator (clear has priority over add).
// Revision : 1.0 - initial release
// ============================================================================
module pid_mac_unit
    import pid_pkg::*;
#(
    parameter int VAL_LENGTH  = 32,
    parameter int COEF_LENGTH = 16
) (
    input  logic                                     sys_clk,
    input  logic                                     sys_rst_n,
    input  logic                                     acc_clr,
    input  logic                                     acc_add,
    input  logic [1:0]                               sel,
    input  logic signed [VAL_LENGTH-1:0]             e0,
    input  logic signed [VAL_LENGTH:0]               d1,
    input  logic signed [VAL_LENGTH+1:0]             d2,
    input  logic signed [COEF_LENGTH-1:0]            kp,
    input  logic signed [COEF_LENGTH-1:0]            ki,
    input  logic signed [COEF_LENGTH-1:0]            kd,
    output logic signed [VAL_LENGTH+COEF_LENGTH+3:0] acc
);

    localparam int c_op_w   = d2_width(VAL_LENGTH);
    localparam int c_prod_w = prod_width(VAL_LENGTH, COEF_LENGTH);
    localparam int c_acc_w  = acc_width(VAL_LENGTH, COEF_LENGTH);

    logic signed [c_op_w-1:0]      w_op;
    logic signed [COEF_LENGTH-1:0] w_coef;
    logic signed [c_prod_w-1:0]    w_prod;
    logic signed [c_acc_w-1:0]     r_acc;

    always_comb begin
        w_op   = '0;
        w_coef = '0;
        case (sel)
            SEL_P: begin
                w_op   = c_op_w'(d1);
                w_coef = kp;
            end
            SEL_I: begin
                w_op   = c_op_w'(e0);
                w_coef = ki;
            end
            SEL_D: begin
                w_op   = d2;
                w_coef = kd;
            end
            default: ;
        endcase
    end

    assign w_prod = c_prod_w'(w_op) * c_prod_w'(w_coef);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_acc <= '0;
        end else if (acc_clr) begin
            r_acc <= '0;
        end else if (acc_add) begin
            r_acc <= r_acc + c_acc_w'(w_prod);
        end
    end

    assign acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/pid_channel_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : pid_channel_scheduler
// Brief    : Sweeps NUM_CH incremental-PID channels through one shared MAC on
//            every accepted sample strobe, with saturated per-channel outputs.
// Revision : 1.0 - initial release
// ============================================================================
module pid_channel_scheduler
    import pid_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int VAL_LENGTH  = 32,
    parameter int COEF_LENGTH = 16,
    parameter int FRAC_BITS   = 8,
    parameter logic signed [VAL_LENGTH-1:0] OUT_MAX = {1'b0, {(VAL_LENGTH-1){1'b1}}},
    parameter logic signed [VAL_LENGTH-1:0] OUT_MIN = {1'b1, {(VAL_LENGTH-1){1'b0}}}
) (
    input  logic                           sys_clk,
    input  logic                           sys_rst_n,
    input  logic                           start,
    input  logic                           clr,
    input  logic [NUM_CH-1:0]              ch_en,
    input  logic [COEF_LENGTH-1:0]         kp,
    input  logic [COEF_LENGTH-1:0]         ki,
    input  logic [COEF_LENGTH-1:0]         kd,
    input  logic [NUM_CH*VAL_LENGTH-1:0]   target_flat,
    input  logic [NUM_CH*VAL_LENGTH-1:0]   current_flat,
    output logic [NUM_CH*VAL_LENGTH-1:0]   out_flat,
    output logic [NUM_CH-1:0]              out_valid,
    output logic [NUM_CH-1:0]              sat,
    output logic                           busy,
    output logic                           done,
    output logic                           overrun
);

    localparam int c_d1_w  = d1_width(VAL_LENGTH);
    localparam int c_d2_w  = d2_width(VAL_LENGTH);
    localparam int c_acc_w = acc_width(VAL_LENGTH, COEF_LENGTH);
    localparam int c_sum_w = c_acc_w + 1;
    localparam int c_ch_w  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [c_ch_w-1:0] c_last = c_ch_w'(NUM_CH - 1);

    pid_state_t                     r_state;
    logic [c_ch_w-1:0]              r_ch;
    logic signed [VAL_LENGTH-1:0]   r_tgt [NUM_CH];
    logic signed [VAL_LENGTH-1:0]   r_cur [NUM_CH];
    logic signed [VAL_LENGTH-1:0]   r_e1  [NUM_CH];
    logic signed [VAL_LENGTH-1:0]   r_e2  [NUM_CH];
    logic signed [VAL_LENGTH-1:0]   r_u   [NUM_CH];
    logic signed [COEF_LENGTH-1:0]  r_kp;
    logic signed [COEF_LENGTH-1:0]  r_ki;
    logic signed [COEF_LENGTH-1:0]  r_kd;
    logic [NUM_CH-1:0]              r_en;
    logic [NUM_CH-1:0]              r_sat;
    logic [NUM_CH-1:0]              r_valid;
    logic                           r_busy;
    logic                           r_done;
    logic signed [VAL_LENGTH-1:0]   r_e0;
    logic signed [c_d1_w-1:0]       r_d1;
    logic signed [c_d2_w-1:0]       r_d2;

    logic signed [VAL_LENGTH-1:0]   w_e0;
    logic signed [c_d1_w-1:0]       w_d1;
    logic signed [c_d2_w-1:0]       w_d2;
    logic signed [c_acc_w-1:0]      w_acc;
    logic signed [c_acc_w-1:0]      w_du;
    logic signed [c_sum_w-1:0]      w_sum;
    logic signed [SAT_W-1:0]        w_sum_ext;
    logic signed [SAT_W-1:0]        w_sat;
    logic signed [VAL_LENGTH-1:0]   w_u_new;
    logic                           w_clamped;
    logic                           w_acc_clr;
    logic                           w_acc_add;
    logic [1:0]                     w_sel;

    assign w_e0 = r_tgt[r_ch] - r_cur[r_ch];
    assign w_d1 = c_d1_w'(w_e0) - c_d1_w'(r_e1[r_ch]);
    assign w_d2 = c_d2_w'(w_e0) - (c_d2_w'(r_e1[r_ch]) <<< 1) + c_d2_w'(r_e2[r_ch]);

    // Floor division of the fixed-point sum; u + du is kept at full width so
    // the clamp sees the true value before truncation.
    assign w_du      = w_acc >>> FRAC_BITS;
    assign w_sum     = c_sum_w'(w_du) + c_sum_w'(r_u[r_ch]);
    assign w_sum_ext = SAT_W'(w_sum);
    assign w_sat     = sat_clamp(w_sum_ext, SAT_W'(OUT_MIN), SAT_W'(OUT_MAX));
    assign w_clamped = (w_sat != w_sum_ext);
    assign w_u_new   = w_sat[VAL_LENGTH-1:0];

    assign w_acc_clr = clr || (r_state == S_LOAD);
    assign w_acc_add = (r_state == S_MUL_P) || (r_state == S_MUL_I) || (r_state == S_MUL_D);

    always_comb begin
        w_sel = SEL_P;
        case (r_state)
            S_MUL_I: w_sel = SEL_I;
            S_MUL_D: w_sel = SEL_D;
            default: w_sel = SEL_P;
        endcase
    end

    pid_mac_unit #(
        .VAL_LENGTH  (VAL_LENGTH),
        .COEF_LENGTH (COEF_LENGTH)
    ) u_mac (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .acc_clr   (w_acc_clr),
        .acc_add   (w_acc_add),
        .sel       (w_sel),
        .e0        (r_e0),
        .d1        (r_d1),
        .d2        (r_d2),
        .kp        (r_kp),
        .ki        (r_ki),
        .kd        (r_kd),
        .acc       (w_acc)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= S_IDLE;
            r_ch    <= '0;
            r_kp    <= '0;
            r_ki    <= '0;
            r_kd    <= '0;
            r_en    <= '0;
            r_sat   <= '0;
            r_valid <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_e0    <= '0;
            r_d1    <= '0;
            r_d2    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_tgt[i] <= '0;
                r_cur[i] <= '0;
                r_e1[i]  <= '0;
                r_e2[i]  <= '0;
                r_u[i]   <= '0;
            end
        end else if (clr) begin
            r_state <= S_IDLE;
            r_ch    <= '0;
            r_sat   <= '0;
            r_valid <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_e1[i] <= '0;
                r_e2[i] <= '0;
                r_u[i]  <= '0;
            end
        end else begin
            r_valid <= '0;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            r_tgt[i] <= target_flat[i*VAL_LENGTH +: VAL_LENGTH];
                            r_cur[i] <= current_flat[i*VAL_LENGTH +: VAL_LENGTH];
                        end
                        r_kp    <= kp;
                        r_ki    <= ki;
                        r_kd    <= kd;
                        r_en    <= ch_en;
                        r_ch    <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (!r_en[r_ch]) begin
                        r_done  <= (r_ch == c_last);
                        r_state <= S_NEXT;
                    end else begin
                        r_e0    <= w_e0;
                        r_d1    <= w_d1;
                        r_d2    <= w_d2;
                        r_state <= S_MUL_P;
                    end
                end
                S_MUL_P: r_state <= S_MUL_I;
                S_MUL_I: r_state <= S_MUL_D;
                S_MUL_D: r_state <= S_ACC;
                S_ACC: begin
                    r_u[r_ch]     <= w_u_new;
                    r_sat[r_ch]   <= w_clamped;
                    r_e2[r_ch]    <= r_e1[r_ch];
                    r_e1[r_ch]    <= r_e0;
                    r_valid[r_ch] <= 1'b1;
                    // done is raised one cycle early so it lands in the NEXT cycle
                    r_done        <= (r_ch == c_last);
                    r_state       <= S_NEXT;
                end
                S_NEXT: begin
                    if (r_ch == c_last) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_ch    <= r_ch + c_ch_w'(1);
                        r_state <= S_LOAD;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_pack
            assign out_flat[gi*VAL_LENGTH +: VAL_LENGTH] = r_u[gi];
        end
    endgenerate

    assign out_valid = r_valid;
    assign sat       = r_sat;
    assign busy      = r_busy;
    assign done      = r_done;
    assign overrun   = start && !clr && (r_state != S_IDLE);

endmodule
`default_nettype wire
